// File: rtl/fetch_pkg.sv
// Shared constants and the in-flight fetch slot type for the fetch unit.
package fetch_pkg;

  localparam int unsigned INSTRUCTION_BYTES = 4;
  localparam int unsigned ROM_LATENCY_MAX   = 4;
  localparam int unsigned PC_WIDTH_MAX      = 32;

  // One stage of the ROM-latency tracking pipeline.
  typedef struct packed {
    logic                    valid;
    logic [PC_WIDTH_MAX-1:0] pc;
  } inflight_slot_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head entry is presented directly from storage.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned COUNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [COUNT_W-1:0] count_q;
  logic               do_push;
  logic               do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == COUNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem[rd_ptr_q];
  assign do_push   = push && !clear;
  assign do_pop    = pop && !empty && !clear;

  // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + COUNT_W'(do_push) - COUNT_W'(do_pop);
    end
  end

  // Entry storage; needs no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(do_push && full && !do_pop));

endmodule

// File: rtl/fetch_queue.sv
// Credit-limited sequential instruction fetch with a decode-side queue and redirect squash.
// A popped entry frees its credit one cycle later, so sustained one-per-cycle
// delivery needs DEPTH >= ROM_LATENCY+2; smaller queues still deliver in order.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned             ADDRESS_WIDTH = 32,
  parameter int unsigned             DATA_WIDTH    = 32,
  parameter int unsigned             DEPTH         = 4,
  parameter int unsigned             ROM_LATENCY   = 1,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     rom_chip_enable,
  output logic [ADDRESS_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  input  logic                     redirect_enable,
  input  logic [ADDRESS_WIDTH-1:0] redirect_address,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_program_counter,
  output logic [DATA_WIDTH-1:0]    out_instruction
);

  localparam int unsigned CREDIT_W = $clog2(DEPTH+1);
  localparam int unsigned ENTRY_W  = ADDRESS_WIDTH + DATA_WIDTH;

  if (ROM_LATENCY < 1 || ROM_LATENCY > ROM_LATENCY_MAX) begin : g_bad_latency
    $error("fetch_queue: ROM_LATENCY out of range");
  end
  if (ADDRESS_WIDTH > PC_WIDTH_MAX) begin : g_bad_width
    $error("fetch_queue: ADDRESS_WIDTH exceeds slot pc width");
  end

  logic                     running_q;
  logic [ADDRESS_WIDTH-1:0] fetch_pc_q;
  logic [ADDRESS_WIDTH-1:0] fetch_pc_d;
  inflight_slot_t           slot_q [ROM_LATENCY];
  inflight_slot_t           slot_d [ROM_LATENCY];

  logic [CREDIT_W-1:0]      fifo_count;
  logic [CREDIT_W-1:0]      inflight_cnt;
  logic [CREDIT_W-1:0]      credit;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [ENTRY_W-1:0]       fifo_head;
  logic [ENTRY_W-1:0]       push_data;
  logic                     issue;
  logic                     push;
  logic                     pop;

  // Credits held by requests still travelling through the ROM.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + CREDIT_W'(slot_q[i].valid);
    end
  end

  // Credit uses registered state only, so out_ready never reaches rom_chip_enable.
  assign credit          = fifo_count + inflight_cnt;
  assign issue           = running_q && (credit < CREDIT_W'(DEPTH)) && !redirect_enable;
  assign rom_chip_enable = issue;
  assign rom_address     = fetch_pc_q;

  assign push      = slot_q[ROM_LATENCY-1].valid;
  assign push_data = {ADDRESS_WIDTH'(slot_q[ROM_LATENCY-1].pc), rom_data};
  assign pop       = !fifo_empty && out_ready;

  // Next fetch PC and latency pipeline; redirect wipes everything in flight.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    for (int i = 0; i < ROM_LATENCY; i++) slot_d[i] = '0;
    if (redirect_enable) begin
      fetch_pc_d = redirect_address;
    end else begin
      slot_d[0].valid = issue;
      slot_d[0].pc    = PC_WIDTH_MAX'(fetch_pc_q);
      for (int i = 1; i < ROM_LATENCY; i++) slot_d[i] = slot_q[i-1];
      if (issue) fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(INSTRUCTION_BYTES);
    end
  end

  // Fetch state registers; issue starts on the first edge after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      running_q  <= 1'b0;
      fetch_pc_q <= RESET_VECTOR;
      for (int i = 0; i < ROM_LATENCY; i++) slot_q[i] <= '0;
    end else begin
      running_q  <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      for (int i = 0; i < ROM_LATENCY; i++) slot_q[i] <= slot_d[i];
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (redirect_enable),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign {out_program_counter, out_instruction} = fifo_empty ? '0 : fifo_head;

  a_credit_cap: assert property (@(posedge clock) disable iff (!reset)
    credit <= CREDIT_W'(DEPTH));
  a_full_credit: assert property (@(posedge clock) disable iff (!reset)
    fifo_full |-> (credit == CREDIT_W'(DEPTH)));

endmodule
